updown_load_counter: RTL and testbench

//  Synthesizable up/down modulo counter. It is the responder end of counter_interface:
//  it consumes UP_or_DOWN, START_or_STOP, LOAD and IN, and produces the count plus status flags.
//  It sits behind counter_interface as the DUT for first_counter_tb-style stimulus.
//  It also serves as a reusable event/timer counter in larger designs.

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_step.sv | 37 +++
 rtl/updown_load_counter.sv | 81 ++++++++
 tb/tb_updown_load_counter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down load counter.
// Holds the FSM state encoding and the direction encodings.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } cnt_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_step.sv
// Combinational modulo step: next count and wrap flag for one step.
// Ports: cur (current count), dir (1=up), max_val (top of range) -> nxt, wrap.
module counter_step
    import counter_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0] cur,
    input  logic         dir,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] nxt,
    output logic         wrap
);

    // Wrap is decided against max_val, not the natural W-bit overflow,
    // so ranges shorter than 2**W behave as true modulo counters.
    always_comb begin
        nxt  = cur;
        wrap = 1'b0;
        if (dir == DIR_UP) begin
            if (cur == max_val) begin
                nxt  = '0;
                wrap = 1'b1;
            end else begin
                nxt = cur + W'(1);
            end
        end else begin
            if (cur == '0) begin
                nxt  = max_val;
                wrap = 1'b1;
            end else begin
                nxt = cur - W'(1);
            end
        end
    end

endmodule

// File: rtl/updown_load_counter.sv
// Up/down modulo counter with synchronous load, run/hold FSM and status flags.
// Ports: CLK, RST (async active-low), UP_or_DOWN, START_or_STOP, LOAD, IN -> OUT, TC, RUNNING, LOAD_CLIP.
module updown_load_counter
    import counter_pkg::*;
#(
    parameter int HOW_MANY_BITS = 3,
    parameter int MAX_VAL       = 2**HOW_MANY_BITS - 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     UP_or_DOWN,
    input  logic                     START_or_STOP,
    input  logic                     LOAD,
    input  logic [HOW_MANY_BITS-1:0] IN,
    output logic [HOW_MANY_BITS-1:0] OUT,
    output logic                     TC,
    output logic                     RUNNING,
    output logic                     LOAD_CLIP
);

    localparam int W = HOW_MANY_BITS;
    localparam logic [W-1:0] MAX_V = W'(MAX_VAL);

    cnt_state_t   state;
    logic [W-1:0] step_val;
    logic         step_wrap;
    logic         over;
    logic [W-1:0] ld_val;

    counter_step #(
        .W(W)
    ) u_step (
        .cur    (OUT),
        .dir    (UP_or_DOWN),
        .max_val(MAX_V),
        .nxt    (step_val),
        .wrap   (step_wrap)
    );

    assign over   = (IN > MAX_V);
    assign ld_val = over ? MAX_V : IN;

    // Every state leaves on START_or_STOP alone, so the next state is
    // RUN or HOLD; the count step uses the state held at this edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            OUT       <= '0;
            TC        <= 1'b0;
            RUNNING   <= 1'b0;
            LOAD_CLIP <= 1'b0;
        end else begin
            unique case (state)
                IDLE,
                RUN,
                HOLD: begin
                    state   <= START_or_STOP ? RUN : HOLD;
                    RUNNING <= START_or_STOP;
                end
                default: begin
                    state   <= IDLE;
                    RUNNING <= 1'b0;
                end
            endcase

            if (LOAD) begin
                OUT <= ld_val;
                TC  <= 1'b0;
                if (over) begin
                    LOAD_CLIP <= 1'b1;
                end
            end else if (state == RUN) begin
                OUT <= step_val;
                TC  <= step_wrap;
            end else begin
                TC <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_updown_load_counter.sv
// Self-checking bench: default and MAX_VAL=5 counters against a modulo model.
// Directed scenarios first, then randomized stimulus with occasional async resets.
module tb_updown_load_counter;

    logic       clk;
    logic       rst;
    logic       dir;
    logic       start;
    logic       load;
    logic [2:0] din;

    logic [2:0] out0, out1;
    logic       tc0, tc1;
    logic       run0, run1;
    logic       clip0, clip1;

    int errors;
    int checks;

    int mx [2];
    int mo [2];
    int mt [2];
    int mc [2];
    int mrun;

    updown_load_counter u_dut0 (
        .CLK          (clk),
        .RST          (rst),
        .UP_or_DOWN   (dir),
        .START_or_STOP(start),
        .LOAD         (load),
        .IN           (din),
        .OUT          (out0),
        .TC           (tc0),
        .RUNNING      (run0),
        .LOAD_CLIP    (clip0)
    );

    updown_load_counter #(
        .HOW_MANY_BITS(3),
        .MAX_VAL      (5)
    ) u_dut1 (
        .CLK          (clk),
        .RST          (rst),
        .UP_or_DOWN   (dir),
        .START_or_STOP(start),
        .LOAD         (load),
        .IN           (din),
        .OUT          (out1),
        .TC           (tc1),
        .RUNNING      (run1),
        .LOAD_CLIP    (clip1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mo[k] = 0;
            mt[k] = 0;
            mc[k] = 0;
        end
        mrun = 0;
    endtask

    // Counting is enabled on an edge iff START was high on the previous
    // edge (and no reset since); arithmetic is plain modulo (max+1).
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (load) begin
                mo[k] = (int'(din) > mx[k]) ? mx[k] : int'(din);
                if (int'(din) > mx[k]) mc[k] = 1;
                mt[k] = 0;
            end else if (mrun != 0) begin
                if (dir) begin
                    mt[k] = (mo[k] == mx[k]) ? 1 : 0;
                    mo[k] = (mo[k] + 1) % (mx[k] + 1);
                end else begin
                    mt[k] = (mo[k] == 0) ? 1 : 0;
                    mo[k] = (mo[k] + mx[k]) % (mx[k] + 1);
                end
            end else begin
                mt[k] = 0;
            end
        end
        mrun = start ? 1 : 0;
    endtask

    task automatic compare_all();
        check("out0", int'(out0), mo[0]);
        check("tc0", int'(tc0), mt[0]);
        check("running0", int'(run0), mrun);
        check("clip0", int'(clip0), mc[0]);
        check("out1", int'(out1), mo[1]);
        check("tc1", int'(tc1), mt[1]);
        check("running1", int'(run1), mrun);
        check("clip1", int'(clip1), mc[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Asserts reset mid-cycle, checks the async clear, holds 3 edges.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (3) begin
            @(posedge clk);
            #1;
            compare_all();
        end
        rst = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mx[0] = 7;
        mx[1] = 5;
        rst   = 1'b0;
        dir   = 1'b1;
        start = 1'b0;
        load  = 1'b0;
        din   = 3'd0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset mid-run at OUT=5, then restart 1,2,3.
        start = 1'b1;
        dir   = 1'b1;
        repeat (6) tick();
        check("t1_pre5", int'(out0), 5);
        do_reset();
        check("t1_rst_out", int'(out0), 0);
        check("t1_rst_run", int'(run0), 0);
        tick();
        tick();
        check("t1_c1", int'(out0), 1);
        tick();
        check("t1_c2", int'(out0), 2);
        tick();
        check("t1_c3", int'(out0), 3);

        // Up wrap 7->0 with TC.
        repeat (4) tick();
        check("t2_at7", int'(out0), 7);
        check("t2_tc_lo", int'(tc0), 0);
        tick();
        check("t2_wrap", int'(out0), 0);
        check("t2_tc_hi", int'(tc0), 1);
        repeat (7) tick();
        check("t2_tc_gap", int'(tc0), 0);
        tick();
        check("t2_tc_8", int'(tc0), 1);

        // Down from 2: 1,0,7,6.
        load = 1'b1;
        din  = 3'd2;
        tick();
        check("t3_ld2", int'(out0), 2);
        load = 1'b0;
        dir  = 1'b0;
        tick();
        check("t3_d1", int'(out0), 1);
        tick();
        check("t3_d0", int'(out0), 0);
        check("t3_tc0", int'(tc0), 0);
        tick();
        check("t3_d7", int'(out0), 7);
        check("t3_tc7", int'(tc0), 1);
        tick();
        check("t3_d6", int'(out0), 6);
        check("t3_tc6", int'(tc0), 0);

        // Load while running, then load while holding.
        dir  = 1'b1;
        load = 1'b1;
        din  = 3'd4;
        tick();
        check("t4_ld4", int'(out0), 4);
        load = 1'b0;
        tick();
        check("t4_s5", int'(out0), 5);
        start = 1'b0;
        tick();
        load = 1'b1;
        din  = 3'd7;
        tick();
        check("t4_ld7", int'(out0), 7);
        load = 1'b0;
        tick();
        tick();
        check("t4_hold7", int'(out0), 7);
        check("t4_run", int'(run0), 0);

        // Clipping on the MAX_VAL=5 instance.
        check("t5_clip", int'(clip1), 1);
        check("t5_clip0", int'(clip0), 0);
        check("t5_out", int'(out1), 5);
        start = 1'b1;
        tick();
        tick();
        check("t5_wrap", int'(out1), 0);
        check("t5_tc", int'(tc1), 1);
        check("t5_sticky", int'(clip1), 1);

        // Stop at 3 -> one more step to 4, then hold; load+reset.
        load = 1'b1;
        din  = 3'd3;
        tick();
        load  = 1'b0;
        start = 1'b0;
        tick();
        check("t6_s4", int'(out0), 4);
        check("t6_run", int'(run0), 0);
        tick();
        check("t6_hold4", int'(out0), 4);
        load = 1'b1;
        din  = 3'd6;
        do_reset();
        check("t6_rst_win", int'(out0), 0);
        load = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end
            start = ($urandom_range(0, 3) != 0);
            dir   = $urandom_range(0, 1) == 1;
            load  = ($urandom_range(0, 7) == 0);
            din   = 3'($urandom_range(0, 7));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
